// File: rtl/stp_sr_rx_framed.sv
// Serial-to-parallel receive deserialiser: shifts SDA on qualified SCL rising edges,
// hands completed words to a holding register (valid/ready), flags overruns.
module stp_sr_rx_framed #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        SDA_sync,
  input  logic                        rising_edge,
  input  logic                        rx_enable,
  input  logic                        frame_clear,
  input  logic                        rx_ready,
  input  logic                        clr_overrun,
  output logic [NUM_BITS-1:0]         shift_out,
  output logic [$clog2(NUM_BITS)-1:0] bit_count,
  output logic [NUM_BITS-1:0]         rx_data,
  output logic                        rx_valid,
  output logic                        byte_done,
  output logic                        overrun
);

  localparam int CW = $clog2(NUM_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_pend_q, done_pend_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic                shift_s;
  logic                complete_s;
  logic                free_s;
  logic [NUM_BITS-1:0] shifted_s;

  assign shift_s    = rx_enable & rising_edge & ~frame_clear;
  assign complete_s = shift_s & (cnt_q == LAST_BIT);
  assign free_s     = ~valid_q | rx_ready;

  // Post-shift word in the configured bit order
  always_comb begin
    shifted_s = shift_q;
    if (SHIFT_MSB) begin
      shifted_s = {shift_q[NUM_BITS-2:0], SDA_sync};
    end else begin
      shifted_s = {SDA_sync, shift_q[NUM_BITS-1:1]};
    end
  end

  // Next-state for shifter, counter, holding register and flags
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;
    done_pend_d = complete_s;
    done_d      = done_pend_q;

    // frame_clear discards a coincident edge, so it is tested before the shift
    if (frame_clear) begin
      shift_d = {NUM_BITS{1'b0}};
      cnt_d   = {CW{1'b0}};
    end else if (shift_s) begin
      shift_d = shifted_s;
      if (cnt_q == LAST_BIT) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      shift_d = shift_q;
    end

    if (complete_s && free_s) begin
      data_d  = shifted_s;
      valid_d = 1'b1;
    end else if (valid_q && rx_ready && !complete_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    // A dropped word beats a simultaneous clear
    if (complete_s && !free_s) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q     <= {NUM_BITS{1'b0}};
      cnt_q       <= {CW{1'b0}};
      data_q      <= {NUM_BITS{1'b0}};
      valid_q     <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  assign shift_out = shift_q;
  assign bit_count = cnt_q;
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign byte_done = done_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/stp_sr_rx_framed.md
Name: stp_sr_rx_framed

Overview:
- Parametrised serial-to-parallel receive deserialiser for the bus slave datapath.
- Samples SDA_sync on qualified SCL rising edges and counts bits within a word.
- On each completed word, transfers it to a holding register with a valid/ready handshake and a one-cycle completion pulse.
- Flags overrun and supports mid-frame abort on START/STOP. Sits between the bus edge/start-stop detectors and the slave controller FSM.

Parameters:
- NUM_BITS, 8: word width in bits; legal range 2 to 32.
- SHIFT_MSB, 1: 1 = first received bit lands in MSB; 0 = first received bit lands in LSB.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- SDA_sync  input  1  synchronised serial data.
- rising_edge  input  1  one-cycle strobe, SCL rising edge detected.
- rx_enable  input  1  receive window; shifting allowed only while high.
- frame_clear  input  1  one-cycle strobe on START/STOP; aborts the partial word.
- rx_ready  input  1  consumer accepts the holding register this cycle.
- clr_overrun  input  1  clears the sticky overrun flag.
- shift_out  output  NUM_BITS  live shift register contents.
- bit_count  output  $clog2(NUM_BITS)  bits received in the current word, 0..NUM_BITS-1.
- rx_data  output  NUM_BITS  holding register, the last completed word.
- rx_valid  output  1  holding register holds an unconsumed word.
- byte_done  output  1  one-cycle pulse after each word completes.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (rst=1 at clk edge): shift_out, bit_count, rx_data, rx_valid, byte_done and overrun all go to 0. Reset overrides every other input.
- Shift qualifier: shift = rx_enable & rising_edge & ~frame_clear.
- Shift direction on a shift:
  - SHIFT_MSB=1: shift_out <= {shift_out[NUM_BITS-2:0], SDA_sync}.
  - SHIFT_MSB=0: shift_out <= {SDA_sync, shift_out[NUM_BITS-1:1]}.
- Bit counter:
  - On a shift with bit_count < NUM_BITS-1: bit_count increments.
  - On a shift with bit_count == NUM_BITS-1: the word completes and bit_count wraps to 0.
- Completion, same edge as the final shift:
  - next_word = the post-shift value.
  - If the holding register is free (rx_valid=0, or rx_valid=1 with rx_ready=1 this cycle): rx_data <= next_word, rx_valid <= 1.
  - Otherwise (rx_valid=1, rx_ready=0): rx_data is unchanged, rx_valid stays 1, overrun <= 1.
  - byte_done is 1 in the cycle after completion, for exactly one cycle, whether or not overrun occurred.
- shift_out is not cleared on completion; it is overwritten by subsequent shifts.
- Handshake: rx_valid=1 with rx_ready=1 and no completion → rx_valid <= 0 next cycle; rx_data holds its value. rx_ready with rx_valid=0 has no effect.
- frame_clear: shift_out <= 0 and bit_count <= 0. It beats a coincident rising_edge: that bit is discarded and no completion occurs. rx_data, rx_valid and overrun are unaffected.
- rx_enable=0: shift_out and bit_count hold. The partial word resumes when rx_enable returns high.
- overrun: set by a dropped word; cleared by clr_overrun. If set and clear occur in the same cycle, set wins.
- Latency: SDA sample to rx_data/rx_valid is 1 cycle on the final bit; byte_done follows 1 cycle later.
- rising_edge on consecutive cycles must be handled, shifting every cycle.

Test Plan:
- Reset, then 8 shifts of 1,0,1,0,0,1,0,1 with SHIFT_MSB=1 → rx_data=0xA5, rx_valid=1 the cycle after bit 8, byte_done a single pulse one cycle later, bit_count=0.
- Same bits with SHIFT_MSB=0 and NUM_BITS=8 → rx_data=0xA5 with bit order reversed, i.e. first bit in LSB, giving 0xA5 mirrored = 0xA5. Repeat with 1,1,0,0,0,0,0,0 → 0x03.
- Hold rx_ready=0 and receive 0x3C then 0xC3 → rx_data stays 0x3C, overrun=1, byte_done pulses twice. Pulse clr_overrun → overrun=0.
- Receive a word with rx_ready=1 on the completion edge while rx_valid=1 (old 0x11, new 0x22) → rx_data=0x22, rx_valid=1, overrun=0.
- After 5 bits, pulse frame_clear coincident with rising_edge → bit_count=0, shift_out=0. Then 8 bits of 0xFF → rx_data=0xFF.
- Deassert rx_enable after 3 bits, pulse rising_edge 4 times, re-enable and send 5 more bits → exactly one word completes, containing the 8 enabled bits. Assert rst mid-word → all outputs 0 on the next cycle.
